wb_select_unit: RTL and testbench
=================================

Name: wb_select_unit

Overview:
- Registered, parametrised successor to the combinational writeback data selector.
- Accepts one retiring instruction per handshake.
- Selects its writeback source: ALU, load, link or CSR.
- For loads, waits for the memory response, then aligns and sign/zero-extends the loaded data.
- Drives the register-file write port one cycle later.
- Sits between the memory stage and the register file of the 64-bit pipeline.

Parameters:
- XLEN, 64, datapath width in bits; must be 32 or 64.
- RA_W, 5, register address width.
- CNT_W, 32, retire counter width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  instruction presented
- in_ready  out  1  unit can accept
- in_kind  in  2  source select: 0 ALU, 1 LOAD, 2 LINK (JAL/JALR), 3 CSR
- in_rd  in  RA_W  destination register
- in_alu  in  XLEN  ALU result
- in_pc_add4  in  XLEN  link value
- in_csr  in  XLEN  CSR read value
- in_addr_lo  in  3  low load-address bits (byte offset within the XLEN word)
- in_size  in  2  load size: 0 byte, 1 half, 2 word, 3 dword (3 is illegal when XLEN=32)
- in_unsigned  in  1  zero-extend the load
- flush  in  1  drop any pending load
- mem_rvalid  in  1  load response valid
- mem_rdata  in  XLEN  raw aligned memory word
- wb_en  out  1  register-file write enable
- wb_rd  out  RA_W  write address
- wb_data  out  XLEN  write data
- wb_misalign  out  1  one-cycle pulse on a misaligned load
- retire_cnt  out  CNT_W  instructions retired

Behaviour:
- Clock and reset: single clock, clk. Synchronous active-high reset, named reset.
- Reset values: state=IDLE, in_ready=1, wb_en=0, wb_rd=0, wb_data=0, wb_misalign=0, retire_cnt=0.
  - Reset during WAIT_MEM abandons the load.
  - No write is produced for the abandoned load.
- States: IDLE and WAIT_MEM. in_ready=1 only in IDLE.
- IDLE, accept with kind≠LOAD:
  - On the next cycle, wb_en=(in_rd≠0), wb_rd=in_rd.
  - wb_data = in_alu, in_pc_add4 or in_csr per in_kind.
  - Latency is 1 cycle.
- IDLE, accept with kind=LOAD:
  - Latch rd, addr_lo, size and unsigned.
  - Go to WAIT_MEM.
- Misaligned load: addr_lo not a multiple of 2^size.
  - No transition to WAIT_MEM.
  - Next cycle: wb_misalign=1, wb_en=0.
  - retire_cnt is not incremented.
- WAIT_MEM:
  - On mem_rvalid: extract the field at byte offset addr_lo, of width 8·2^size, and extend to XLEN.
  - Sign-extend unless unsigned. Size 3 with XLEN=64 passes mem_rdata unchanged.
  - Register the result with wb_en=(rd≠0).
  - Return to IDLE; in_ready is 1 in the same cycle the result is registered.
- Sampling rules:
  - mem_rvalid is ignored in IDLE.
  - in_valid is ignored while in_ready=0.
- Flush:
  - flush in WAIT_MEM returns to IDLE with no write, even if mem_rvalid is high in the same cycle.
  - flush in IDLE blocks acceptance that cycle.
- Output pulses: wb_en and wb_misalign are single-cycle pulses and are 0 whenever no result is produced.
- Hold behaviour: wb_rd and wb_data hold their last values when wb_en=0.
- retire_cnt:
  - Increments by 1 each cycle a result is registered (wb_en or an rd=0 result), i.e. every completed non-misaligned, non-flushed instruction.
  - Wraps modulo 2^CNT_W.
- Back-to-back throughput: one non-load per cycle with no bubbles.

Test Plan:
- Reset, then ALU op with rd=5, in_alu=0x1234 → next cycle wb_en=1, wb_rd=5, wb_data=0x1234, retire_cnt=1.
- LINK with in_pc_add4=0x80000010 and rd=1, then CSR with in_csr=0x7 and rd=2 on consecutive cycles → two consecutive writes with matching data, no bubble.
- Load byte signed, addr_lo=3, mem_rdata=0x00000000_80FF0000 after a 4-cycle wait → in_ready=0 for the 4 cycles, then wb_data=0xFFFFFFFF_FFFFFF80. Same with in_unsigned=1 → 0x80.
- Load half, addr_lo=1 → wb_misalign pulse, wb_en=0, retire_cnt unchanged, in_ready stays 1.
- Load pending, then flush and mem_rvalid asserted in the same cycle → no wb_en, state IDLE next cycle.
- rd=0 ALU op → wb_en=0, retire_cnt increments. Assert reset in WAIT_MEM → all outputs return to their reset values.

Source files
------------

// File: rtl/wb_select_unit.sv
// wb_select_unit: registered writeback selector with load align/extend and retire counter
module wb_select_unit #(
    parameter int XLEN  = 64,
    parameter int RA_W  = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_kind,
    input  logic [RA_W-1:0]  in_rd,
    input  logic [XLEN-1:0]  in_alu,
    input  logic [XLEN-1:0]  in_pc_add4,
    input  logic [XLEN-1:0]  in_csr,
    input  logic [2:0]       in_addr_lo,
    input  logic [1:0]       in_size,
    input  logic             in_unsigned,
    input  logic             flush,
    input  logic             mem_rvalid,
    input  logic [XLEN-1:0]  mem_rdata,
    output logic             wb_en,
    output logic [RA_W-1:0]  wb_rd,
    output logic [XLEN-1:0]  wb_data,
    output logic             wb_misalign,
    output logic [CNT_W-1:0] retire_cnt
);
    typedef enum logic {IDLE, WAIT_MEM} state_t;

    state_t          state;
    logic [RA_W-1:0] l_rd;
    logic [2:0]      l_addr;
    logic [1:0]      l_size;
    logic            l_uns;

    logic            accept;
    logic            misalign;
    logic [2:0]      mask;
    logic [XLEN-1:0] sel;
    logic [XLEN-1:0] sh;
    logic [63:0]     w;
    logic [63:0]     ext;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready && !flush;

    // Source select, alignment check and load field extraction
    always_comb begin
        mask     = in_size == 2'd0 ? 3'd0 : in_size == 2'd1 ? 3'd1 : in_size == 2'd2 ? 3'd3 : 3'd7;
        misalign = (in_addr_lo & mask) != 3'd0 || (XLEN == 32 && in_size == 2'd3);
        sel      = in_kind == 2'd2 ? in_pc_add4 : in_kind == 2'd3 ? in_csr : in_alu;
        sh       = mem_rdata >> {l_addr, 3'b000};
        w        = 64'(sh);
        ext      = l_size == 2'd0 ? {{56{~l_uns & w[7]}}, w[7:0]} :
                   l_size == 2'd1 ? {{48{~l_uns & w[15]}}, w[15:0]} :
                   l_size == 2'd2 ? {{32{~l_uns & w[31]}}, w[31:0]} : w;
    end

    // Handshake FSM, registered writeback port and retire counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            wb_en       <= 1'b0;
            wb_rd       <= '0;
            wb_data     <= '0;
            wb_misalign <= 1'b0;
            retire_cnt  <= '0;
            l_rd        <= '0;
            l_addr      <= '0;
            l_size      <= '0;
            l_uns       <= 1'b0;
        end else begin
            wb_en       <= 1'b0;
            wb_misalign <= 1'b0;
            if (state == IDLE) begin
                if (accept && in_kind == 2'd1) begin
                    if (misalign) begin
                        wb_misalign <= 1'b1;
                    end else begin
                        l_rd   <= in_rd;
                        l_addr <= in_addr_lo;
                        l_size <= in_size;
                        l_uns  <= in_unsigned;
                        state  <= WAIT_MEM;
                    end
                end else if (accept) begin
                    wb_en      <= in_rd != '0;
                    retire_cnt <= retire_cnt + CNT_W'(1);
                    if (in_rd != '0) begin
                        wb_rd   <= in_rd;
                        wb_data <= sel;
                    end
                end
            end else if (flush) begin
                state <= IDLE;
            end else if (mem_rvalid) begin
                state      <= IDLE;
                wb_en      <= l_rd != '0;
                retire_cnt <= retire_cnt + CNT_W'(1);
                if (l_rd != '0) begin
                    wb_rd   <= l_rd;
                    wb_data <= ext[XLEN-1:0];
                end
            end
        end
    end
endmodule

// File: tb/tb_wb_select_unit.sv
// tb_wb_select_unit: directed checks of the writeback selector
module tb_wb_select_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_kind;
    logic [4:0]  in_rd;
    logic [63:0] in_alu;
    logic [63:0] in_pc_add4;
    logic [63:0] in_csr;
    logic [2:0]  in_addr_lo;
    logic [1:0]  in_size;
    logic        in_unsigned;
    logic        flush;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        wb_misalign;
    logic [31:0] retire_cnt;

    int vectors = 0;
    int miscompares = 0;

    wb_select_unit dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_rd(in_rd), .in_alu(in_alu), .in_pc_add4(in_pc_add4),
        .in_csr(in_csr), .in_addr_lo(in_addr_lo), .in_size(in_size),
        .in_unsigned(in_unsigned), .flush(flush), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_misalign(wb_misalign), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_wb(input string tag, input logic en, input logic [4:0] rd,
                            input logic [63:0] data, input logic [31:0] cnt);
        check({tag, ".wb_en"}, 64'(wb_en), 64'(en));
        check({tag, ".wb_rd"}, 64'(wb_rd), 64'(rd));
        check({tag, ".wb_data"}, wb_data, data);
        check({tag, ".retire_cnt"}, 64'(retire_cnt), 64'(cnt));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        check({tag, ".wb_misalign"}, 64'(wb_misalign), 64'd0);
        check_wb(tag, 1'b0, 5'd0, 64'd0, 32'd0);
    endtask

    task automatic issue(input logic [1:0] kind, input logic [4:0] rd);
        in_valid = 1'b1;
        in_kind  = kind;
        in_rd    = rd;
    endtask

    task automatic do_load(input string tag, input logic [4:0] rd, input logic [2:0] addr,
                           input logic [1:0] size, input logic uns, input logic [63:0] rdata,
                           input int waits, input logic [63:0] exp, input logic [31:0] cnt);
        issue(2'd1, rd);
        in_addr_lo  = addr;
        in_size     = size;
        in_unsigned = uns;
        tick();
        issue(2'd0, 5'd9);
        in_alu = 64'hBAD;
        for (int i = 0; i < waits; i++) begin
            check({tag, ".wait_ready"}, 64'(in_ready), 64'd0);
            check({tag, ".wait_en"}, 64'(wb_en), 64'd0);
            if (i < waits - 1) tick();
        end
        in_valid   = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        tick();
        mem_rvalid = 1'b0;
        check_wb(tag, 1'b1, rd, exp, cnt);
        check({tag, ".ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_kind = 2'd0; in_rd = 5'd0;
        in_alu = '0; in_pc_add4 = '0; in_csr = '0; in_addr_lo = '0; in_size = '0;
        in_unsigned = 1'b0; flush = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        tick(); tick();
        reset = 1'b0;
        check_reset_state("reset");

        issue(2'd0, 5'd5); in_alu = 64'h1234;
        tick();
        in_valid = 1'b0;
        check_wb("alu", 1'b1, 5'd5, 64'h1234, 32'd1);

        issue(2'd2, 5'd1); in_pc_add4 = 64'h8000_0010;
        tick();
        check_wb("link", 1'b1, 5'd1, 64'h8000_0010, 32'd2);
        issue(2'd3, 5'd2); in_csr = 64'h7;
        tick();
        in_valid = 1'b0;
        check_wb("csr", 1'b1, 5'd2, 64'h7, 32'd3);
        tick();
        check_wb("hold", 1'b0, 5'd2, 64'h7, 32'd3);

        mem_rvalid = 1'b1; mem_rdata = 64'hFFFF;
        tick();
        mem_rvalid = 1'b0;
        check_wb("rvalid_idle", 1'b0, 5'd2, 64'h7, 32'd3);

        do_load("lb", 5'd7, 3'd3, 2'd0, 1'b0, 64'h0000_0000_80FF_0000, 4, 64'hFFFF_FFFF_FFFF_FF80, 32'd4);
        do_load("lbu", 5'd8, 3'd3, 2'd0, 1'b1, 64'h0000_0000_80FF_0000, 1, 64'h80, 32'd5);
        do_load("lh", 5'd10, 3'd2, 2'd1, 1'b0, 64'h0000_0000_80FF_0000, 2, 64'hFFFF_FFFF_FFFF_80FF, 32'd6);
        do_load("ld", 5'd11, 3'd0, 2'd3, 1'b0, 64'h0123_4567_89AB_CDEF, 1, 64'h0123_4567_89AB_CDEF, 32'd7);
        do_load("lwu", 5'd13, 3'd4, 2'd2, 1'b1, 64'h89AB_CDEF_0000_0000, 1, 64'h0000_0000_89AB_CDEF, 32'd8);

        issue(2'd1, 5'd3); in_addr_lo = 3'd1; in_size = 2'd1; in_unsigned = 1'b0;
        tick();
        in_valid = 1'b0;
        check("misalign.pulse", 64'(wb_misalign), 64'd1);
        check("misalign.ready", 64'(in_ready), 64'd1);
        check_wb("misalign", 1'b0, 5'd13, 64'h89AB_CDEF, 32'd8);
        tick();
        check("misalign.end", 64'(wb_misalign), 64'd0);

        issue(2'd1, 5'd4); in_addr_lo = 3'd0; in_size = 2'd2;
        tick();
        in_valid = 1'b0;
        check("flush.pending", 64'(in_ready), 64'd0);
        flush = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'h5555;
        tick();
        flush = 1'b0; mem_rvalid = 1'b0;
        check("flush.ready", 64'(in_ready), 64'd1);
        check_wb("flush", 1'b0, 5'd13, 64'h89AB_CDEF, 32'd8);

        issue(2'd0, 5'd6); in_alu = 64'h66; flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        check_wb("flush_idle", 1'b0, 5'd13, 64'h89AB_CDEF, 32'd8);

        issue(2'd0, 5'd0); in_alu = 64'hDEAD;
        tick();
        in_valid = 1'b0;
        check_wb("rd0", 1'b0, 5'd13, 64'h89AB_CDEF, 32'd9);

        issue(2'd1, 5'd12); in_addr_lo = 3'd0; in_size = 2'd0;
        tick();
        in_valid = 1'b0;
        check("rst_wait.pending", 64'(in_ready), 64'd0);
        reset = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'h77;
        tick();
        reset = 1'b0;
        check_reset_state("rst_wait");
        tick();
        mem_rvalid = 1'b0;
        check_reset_state("rst_wait.after");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
